// File: rtl/gray2bin_pipe.sv
// rtl/gray2bin_pipe.sv - elastic pipelined gray-to-binary decoder with adjacency checker
module gray2bin_pipe #(
    parameter int CODE_WIDTH    = 4,
    parameter int PIPE_STAGES   = 2,
    parameter int CHECK_ADJ     = 1,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CODE_WIDTH-1:0]    gray_code,
    input  logic                     gray_code_valid,
    output logic                     gray_code_ready,
    output logic [CODE_WIDTH-1:0]    binary_code,
    output logic                     binary_code_valid,
    input  logic                     binary_code_ready,
    output logic                     adj_err,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);
    localparam int W   = CODE_WIDTH;
    localparam int S   = PIPE_STAGES;
    localparam int BPS = (W + S - 1) / S;

    logic [W-1:0] data_r   [S];
    logic [W-1:0] src_data [S];
    logic [S-1:0] vld;
    logic [S-1:0] adj_r;
    logic [S-1:0] src_vld;
    logic [S-1:0] src_adj;
    logic [S-1:0] rdy;

    logic [W-1:0] prev_code;
    logic         prev_vld;
    logic [W-1:0] diff;
    logic         adj_in;
    logic         in_acc;

    // Bits at or above hi arrive already binary; this stage resolves [lo, hi).
    function automatic logic [W-1:0] resolve(input logic [W-1:0] w, input int stage);
        logic [W-1:0] r;
        int lo;
        int hi;
        r  = w;
        hi = W - stage * BPS;
        lo = hi - BPS;
        if (lo < 0) lo = 0;
        for (int i = W - 2; i >= 0; i--) begin
            if (i >= lo && i < hi) r[i] = r[i+1] ^ r[i];
        end
        return r;
    endfunction

    // A stage may load if any stage from it to the output is empty, or the output drains.
    always_comb begin
        logic any_room;
        any_room = 1'b0;
        rdy      = '0;
        for (int k = 0; k < S; k++) begin
            any_room = binary_code_ready;
            for (int j = k; j < S; j++) any_room = any_room | ~vld[j];
            rdy[k] = any_room;
        end
    end

    always_comb begin
        src_data[0] = gray_code;
        src_vld[0]  = gray_code_valid;
        src_adj[0]  = adj_in;
        for (int k = 1; k < S; k++) begin
            src_data[k] = data_r[k-1];
            src_vld[k]  = vld[k-1];
            src_adj[k]  = adj_r[k-1];
        end
    end

    assign gray_code_ready = ~rst & rdy[0];
    assign in_acc          = gray_code_valid & gray_code_ready;
    assign diff            = gray_code ^ prev_code;
    assign adj_in          = (CHECK_ADJ != 0) & prev_vld & (|(diff & (diff - W'(1))));

    always_ff @(posedge clk) begin
        if (rst) begin
            vld   <= '0;
            adj_r <= '0;
            for (int k = 0; k < S; k++) data_r[k] <= '0;
        end else begin
            for (int k = 0; k < S; k++) begin
                if (rdy[k]) begin
                    vld[k] <= src_vld[k];
                    if (src_vld[k]) begin
                        data_r[k] <= resolve(src_data[k], k);
                        adj_r[k]  <= src_adj[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_code <= '0;
            prev_vld  <= 1'b0;
        end else if (in_acc) begin
            prev_code <= gray_code;
            prev_vld  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (binary_code_valid & binary_code_ready & adj_err & ~&err_count) begin
            err_count <= err_count + ERR_CNT_WIDTH'(1);
        end
    end

    assign binary_code       = data_r[S-1];
    assign binary_code_valid = vld[S-1];
    assign adj_err           = adj_r[S-1];

endmodule
